// File: rtl/datamem_pipe.sv
// Handshaked little-endian data memory with sized/sign-extending loads,
// illegal-access error responses and a saturating error counter.
module datamem_pipe #(
   parameter  int ADDR_W     = 64,
   parameter  int DATA_BYTES = 8,
   parameter  int MEM_BYTES  = 1024,
   parameter  int ERRCNT_W   = 16,
   localparam int SIZE_W     = $clog2(DATA_BYTES) + 2,
   localparam int DATA_W     = 8 * DATA_BYTES,
   localparam int MIDX_W     = $clog2(MEM_BYTES)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic                req_signed,
   input  logic [ADDR_W-1:0]   address,
   input  logic [SIZE_W-1:0]   xfer_size,
   input  logic [DATA_W-1:0]   write_data,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   read_data,
   output logic                resp_err,
   output logic [ERRCNT_W-1:0] err_count
);

   logic [7:0]          mem_q [MEM_BYTES];

   logic                resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   read_data_q, read_data_d;
   logic                resp_err_q, resp_err_d;
   logic [ERRCNT_W-1:0] err_count_q, err_count_d;

   logic                accept;
   logic                size_ok;
   logic                legal;
   logic                store_en;
   logic [ADDR_W-1:0]   align_mask;
   logic [ADDR_W:0]     end_addr;
   logic [MIDX_W-1:0]   base_idx;
   logic [DATA_W-1:0]   rd_raw;

   function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
      return (&v) ? v : v + ERRCNT_W'(1);
   endfunction

   // Keep the low `size` bytes; fill the rest with zero or the top transferred bit.
   function automatic logic [DATA_W-1:0] size_extend(input logic [DATA_W-1:0] raw,
                                                     input logic [SIZE_W-1:0] size,
                                                     input logic              sgn);
      logic              fill;
      logic [DATA_W-1:0] res;
      fill = 1'b0;
      res  = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (int'(size) == i + 1) fill = sgn & raw[8*i+7];
      end
      for (int i = 0; i < DATA_BYTES; i++) begin
         res[8*i +: 8] = (i < int'(size)) ? raw[8*i +: 8] : {8{fill}};
      end
      return res;
   endfunction

   assign req_ready = !resp_valid_q || resp_ready;
   assign accept    = req_valid && req_ready;
   assign base_idx  = address[MIDX_W-1:0];

   // End address is one bit wider than the address so it cannot wrap past zero.
   always_comb begin
      size_ok    = (xfer_size != '0) &&
                   ((xfer_size & (xfer_size - 1'b1)) == '0) &&
                   (xfer_size <= SIZE_W'(DATA_BYTES));
      align_mask = ADDR_W'(xfer_size) - ADDR_W'(1);
      end_addr   = {1'b0, address} + (ADDR_W+1)'(xfer_size);
      legal      = size_ok &&
                   ((address & align_mask) == '0) &&
                   (end_addr <= (ADDR_W+1)'(MEM_BYTES));
      store_en   = accept && legal && req_write;
   end

   always_comb begin
      rd_raw = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         rd_raw[8*i +: 8] = mem_q[base_idx + MIDX_W'(i)];
      end
   end

   always_comb begin
      resp_valid_d = resp_valid_q;
      read_data_d  = read_data_q;
      resp_err_d   = resp_err_q;
      err_count_d  = err_count_q;
      if (accept) begin
         resp_valid_d = 1'b1;
         resp_err_d   = !legal;
         read_data_d  = (legal && !req_write) ? size_extend(rd_raw, xfer_size, req_signed) : '0;
         if (!legal) err_count_d = sat_inc(err_count_q);
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid_q <= 1'b0;
         read_data_q  <= '0;
         resp_err_q   <= 1'b0;
         err_count_q  <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         read_data_q  <= read_data_d;
         resp_err_q   <= resp_err_d;
         err_count_q  <= err_count_d;
      end
   end

   // Storage is never reset; committed stores survive a reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (store_en && (i < int'(xfer_size))) begin
            mem_q[base_idx + MIDX_W'(i)] <= write_data[8*i +: 8];
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign read_data  = read_data_q;
   assign resp_err   = resp_err_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_datamem_pipe.sv
// Directed and randomised bench for datamem_pipe against a byte-array/queue model.
module tb_datamem_pipe;

   localparam int MEMB = 1024;
   localparam int ECW  = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic           req_write = 1'b0;
   logic           req_signed = 1'b0;
   logic [63:0]    address = '0;
   logic [4:0]     xfer_size = '0;
   logic [63:0]    write_data = '0;
   logic           resp_valid;
   logic           resp_ready = 1'b1;
   logic [63:0]    read_data;
   logic           resp_err;
   logic [ECW-1:0] err_count;

   int checks = 0;
   int errors = 0;

   datamem_pipe #(.ADDR_W(64), .DATA_BYTES(8), .MEM_BYTES(MEMB), .ERRCNT_W(ECW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_signed(req_signed),
      .address(address), .xfer_size(xfer_size), .write_data(write_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .read_data(read_data), .resp_err(resp_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [63:0] data;
      logic        err;
   } resp_t;

   logic [7:0] m_mem [MEMB];
   resp_t      m_q[$];
   int         m_err = 0;
   bit         m_acc;
   resp_t      m_r;

   function automatic bit legal_f(input logic [63:0] a, input int sz);
      logic [64:0] endp;
      if (!(sz == 1 || sz == 2 || sz == 4 || sz == 8)) return 0;
      if ((a % 64'(sz)) != 0) return 0;
      endp = {1'b0, a} + 65'(sz);
      return endp <= 65'(MEMB);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_err = 0;
      end else begin
         m_acc = req_valid && ((m_q.size() == 0) || resp_ready);
         if (m_q.size() != 0 && resp_ready) void'(m_q.pop_front());
         if (m_acc) begin
            m_r.data = '0;
            m_r.err  = 1'b0;
            if (!legal_f(address, int'(xfer_size))) begin
               m_r.err = 1'b1;
               if (m_err < (1 << ECW) - 1) m_err++;
            end else if (req_write) begin
               for (int i = 0; i < int'(xfer_size); i++)
                  m_mem[int'(address[9:0]) + i] = write_data[8*i +: 8];
            end else begin
               for (int i = 0; i < int'(xfer_size); i++)
                  m_r.data[8*i +: 8] = m_mem[int'(address[9:0]) + i];
               if (req_signed && m_r.data[8*int'(xfer_size)-1])
                  for (int i = int'(xfer_size); i < 8; i++) m_r.data[8*i +: 8] = 8'hFF;
            end
            m_q.push_back(m_r);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_resp_valid", 64'(resp_valid), 64'd0);
         chk("rst_req_ready", 64'(req_ready), 64'd1);
         chk("rst_err_count", 64'(err_count), 64'd0);
      end else begin
         chk("req_ready", 64'(req_ready), 64'((m_q.size() == 0) || resp_ready));
         chk("resp_valid", 64'(resp_valid), 64'(m_q.size() != 0));
         chk("err_count", 64'(err_count), 64'(m_err));
         if (m_q.size() != 0) begin
            chk("read_data", read_data, m_q[0].data);
            chk("resp_err", 64'(resp_err), 64'(m_q[0].err));
         end
      end
   end

   // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
   task automatic drive(input bit w, input bit s, input logic [63:0] a, input int sz,
                        input logic [63:0] wd);
      req_valid  = 1'b1;
      req_write  = w;
      req_signed = s;
      address    = a;
      xfer_size  = 5'(sz);
      write_data = wd;
   endtask

   task automatic idle();
      req_valid  = 1'b0;
      address    = 'x;
      xfer_size  = 'x;
      write_data = 'x;
   endtask

   task automatic accept();
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic op(input string name, input bit w, input bit s, input logic [63:0] a,
                     input int sz, input logic [63:0] wd,
                     input logic [63:0] exp_rd, input bit exp_err);
      drive(w, s, a, sz, wd);
      accept();
      idle();
      @(negedge clk);
      chk({name, "_vld"}, 64'(resp_valid), 64'd1);
      chk({name, "_data"}, read_data, exp_rd);
      chk({name, "_err"}, 64'(resp_err), 64'(exp_err));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b1;
      idle();
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", 64'(resp_valid), 64'd0);
      chk("reset_errcnt", 64'(err_count), 64'd0);
      chk("reset_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Sized and signed accesses.
      op("st8", 1, 0, 64'h10, 8, 64'h1122334455667788, 64'h0, 0);
      op("ld1u", 0, 0, 64'h10, 1, '0, 64'h88, 0);
      op("ld2s", 0, 1, 64'h16, 2, '0, 64'h1122, 0);
      op("st80", 1, 0, 64'h20, 1, 64'h80, 64'h0, 0);
      op("ld1s", 0, 1, 64'h20, 1, '0, 64'hFFFFFFFFFFFFFF80, 0);
      op("ld4u", 0, 0, 64'h14, 4, '0, 64'h11223344, 0);

      // Error responses.
      op("st_base", 1, 0, 64'h0, 8, 64'h0102030405060708, 64'h0, 0);
      op("ld4_mis", 0, 0, 64'h12, 4, '0, 64'h0, 1);
      op("st3", 1, 0, 64'h0, 3, 64'hFFFFFF, 64'h0, 1);
      op("ld8_oob", 0, 0, 64'(MEMB - 4), 8, '0, 64'h0, 1);
      chk("errcnt3", 64'(err_count), 64'd3);
      op("unchanged", 0, 0, 64'h0, 4, '0, 64'h05060708, 0);
      op("st_top", 1, 0, 64'(MEMB - 4), 4, 64'h89ABCDEF, 64'h0, 0);
      op("ld_top", 0, 1, 64'(MEMB - 4), 4, '0, 64'hFFFFFFFF89ABCDEF, 0);
      op("sz0", 0, 0, 64'h8, 0, '0, 64'h0, 1);
      op("sz16", 0, 0, 64'h0, 16, '0, 64'h0, 1);
      op("wrap", 0, 0, 64'hFFFFFFFFFFFFFFF8, 8, '0, 64'h0, 1);
      chk("errcnt6", 64'(err_count), 64'd6);

      // Back-pressure: first load held, the rest drain one per cycle in order.
      resp_ready = 1'b0;
      drive(0, 0, 64'h10, 1, '0);
      accept();
      drive(0, 0, 64'h11, 1, '0);
      repeat (3) begin
         @(negedge clk);
         chk("bp_ready", 64'(req_ready), 64'd0);
         chk("bp_valid", 64'(resp_valid), 64'd1);
         chk("bp_hold", read_data, 64'h88);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_r1", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 drive(0, 0, 64'h12, 2, '0);
      @(negedge clk);
      chk("bp_d2", read_data, 64'h77);
      chk("bp_r2", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 drive(0, 0, 64'h14, 4, '0);
      @(negedge clk);
      chk("bp_d3", read_data, 64'h5566);
      @(posedge clk);
      #1 idle();
      @(negedge clk);
      chk("bp_d4", read_data, 64'h11223344);
      @(posedge clk);
      #1;

      // Store then load of the same byte on consecutive edges.
      drive(1, 0, 64'h40, 1, 64'hAB);
      accept();
      drive(0, 0, 64'h40, 1, '0);
      accept();
      idle();
      @(negedge clk);
      chk("b2b_data", read_data, 64'hAB);
      @(posedge clk);
      #1;

      // Reset asserted while a response is stalled.
      resp_ready = 1'b0;
      drive(0, 0, 64'h10, 1, '0);
      accept();
      idle();
      @(negedge clk);
      chk("stall_valid", 64'(resp_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_drop", 64'(resp_valid), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_errcnt", 64'(err_count), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      op("mem_kept", 0, 0, 64'h10, 1, '0, 64'h88, 0);

      // Counter saturation.
      for (int k = 0; k < 20; k++) op("illegal", 0, 0, 64'h0, 3, '0, 64'h0, 1);
      chk("errcnt_sat", 64'(err_count), 64'd15);

      // Fill memory back-to-back, then mixed random traffic.
      for (int a = 0; a < MEMB; a += 8) begin
         drive(1, 0, 64'(a), 8, {$urandom, $urandom});
         accept();
      end
      idle();
      for (int k = 0; k < 3000; k++) begin
         resp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0) begin
            int sz;
            logic [63:0] a;
            if ($urandom_range(0, 9) < 7) begin
               sz = 1 << $urandom_range(0, 3);
               a  = 64'($urandom_range(0, MEMB - 1)) & ~64'(sz - 1);
            end else begin
               sz = $urandom_range(0, 31);
               a  = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, MEMB + 64));
            end
            drive($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, a, sz, {$urandom, $urandom});
         end else begin
            idle();
         end
         @(posedge clk);
         #1;
      end
      idle();
      resp_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
